spi_master_cfg: RTL and testbench

//  Parametrised full-duplex SPI master; next generation of the fixed 12-bit SPI master.

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_sclk_gen.sv | 62 ++++++
 rtl/spi_master_cfg.sv | 178 +++++++++++++++++
 tb/tb_spi_master_cfg.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg
//   Shared types for the configurable SPI master.
//   spi_state_e : transfer sequencing states
//   spi_mode_t  : per-transfer mode captured when a request is accepted
//   MIN_DATA_W / MIN_CLK_DIV : smallest legal parameter values
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_mode_t;

  localparam int unsigned MIN_DATA_W  = 2;
  localparam int unsigned MIN_CLK_DIV = 2;

endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen
//   SCLK timing for the SPI master: a divider counter that produces a tick every
//   CLK_DIV cycles while the transfer is active, and an edge counter that numbers
//   the 2*DATA_W SCLK edges during the shifting phase.
// Ports
//   clk        in  system clock
//   rst_n      in  synchronous active-low reset
//   run        in  divider enable (SETUP, XFER, HOLD); counter held at 0 otherwise
//   xfer       in  shifting phase active; edge counter held at 0 otherwise
//   tick       out divider terminal count (one cycle every CLK_DIV cycles)
//   lead_edge  out this tick is an SCLK leading edge (edges 1, 3, 5, ...)
//   trail_edge out this tick is an SCLK trailing edge (edges 2, 4, 6, ...)
//   last_edge  out this tick is edge 2*DATA_W, the final trailing edge
module spi_sclk_gen #(
  parameter int DATA_W  = 12,
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic xfer,
  output logic tick,
  output logic lead_edge,
  output logic trail_edge,
  output logic last_edge
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int EDGE_W = $clog2(2 * DATA_W);
  localparam logic [DIV_W-1:0]  DIV_TC  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_TC = EDGE_W'(2 * DATA_W - 1);

  logic [DIV_W-1:0]  div_cnt;
  logic [EDGE_W-1:0] edge_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
    end else begin
      if (!run || tick) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (!xfer) begin
        edge_cnt <= '0;
      end else if (tick) begin
        edge_cnt <= (edge_cnt == EDGE_TC) ? '0 : edge_cnt + 1'b1;
      end
    end
  end

  assign tick = run && (div_cnt == DIV_TC);

  // Edge counter is zero-based, so even counts are leading edges.
  assign lead_edge  = tick && xfer && !edge_cnt[0];
  assign trail_edge = tick && xfer &&  edge_cnt[0];
  assign last_edge  = tick && xfer && (edge_cnt == EDGE_TC);

endmodule

// File: rtl/spi_master_cfg.sv
// spi_master_cfg
//   Full-duplex SPI master with configurable word width, SCLK divider, all four
//   CPOL/CPHA modes and selectable bit order. One transfer per accepted request.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | cs_n high, sclk follows cpol input, waiting for newd
//   SETUP | cs_n low for CLK_DIV cycles before the first SCLK edge
//   XFER  | 2*DATA_W SCLK edges, one per CLK_DIV cycles, shifting both ways
//   HOLD  | CLK_DIV cycles with sclk at idle level, cs_n still low
//   DONE  | one cycle: cs_n high, done pulse, dout loaded
//
// Ports
//   clk        in  system clock
//   rst_n      in  synchronous active-low reset
//   newd       in  start request, only looked at in IDLE
//   din        in  word to transmit, captured with newd
//   cpol       in  SCLK idle level, captured with newd
//   cpha       in  0: sample on leading edge, 1: sample on trailing edge
//   lsb_first  in  1: bit 0 goes first in both directions
//   miso       in  serial data from slave
//   sclk       out serial clock
//   mosi       out serial data to slave
//   cs_n       out active-low chip select
//   dout       out last received word, updated in the done cycle
//   done       out one-cycle end-of-transfer pulse
//   busy       out high from the cycle after acceptance through the done cycle
module spi_master_cfg
  import spi_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              newd,
  input  logic [DATA_W-1:0] din,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  output logic [DATA_W-1:0] dout,
  output logic              done,
  output logic              busy
);

  spi_state_e        state;
  spi_mode_t         mode;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;

  logic run;
  logic xfer;
  logic tick;
  logic lead_edge;
  logic trail_edge;
  logic last_edge;
  logic shift_edge;
  logic sample_edge;

  assign run  = (state == SETUP) || (state == XFER) || (state == HOLD);
  assign xfer = (state == XFER);

  spi_sclk_gen #(
    .DATA_W (DATA_W),
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .xfer      (xfer),
    .tick      (tick),
    .lead_edge (lead_edge),
    .trail_edge(trail_edge),
    .last_edge (last_edge)
  );

  // With cpha=0 the first bit is already on mosi from acceptance, so the final
  // trailing edge has nothing left to present.
  assign shift_edge  = mode.cpha ? lead_edge  : (trail_edge && !last_edge);
  assign sample_edge = mode.cpha ? trail_edge : lead_edge;

  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] drop_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic [DATA_W-1:0] take_bit(input logic [DATA_W-1:0] w, input logic b,
                                                 input logic lsb);
    return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      mode     <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= 1'b1;
      dout     <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          sclk <= cpol;
          if (newd) begin
            mode     <= {cpol, cpha, lsb_first};
            rx_shift <= '0;
            cs_n     <= 1'b0;
            busy     <= 1'b1;
            state    <= SETUP;
            // cpha=0 slaves sample on the very first edge, so present bit one now.
            if (cpha) begin
              tx_shift <= din;
              mosi     <= 1'b0;
            end else begin
              tx_shift <= drop_bit(din, lsb_first);
              mosi     <= first_bit(din, lsb_first);
            end
          end
        end

        SETUP: begin
          if (tick) begin
            state <= XFER;
          end
        end

        XFER: begin
          if (tick) begin
            sclk <= ~sclk;
          end
          if (shift_edge) begin
            mosi     <= first_bit(tx_shift, mode.lsb_first);
            tx_shift <= drop_bit(tx_shift, mode.lsb_first);
          end
          if (sample_edge) begin
            rx_shift <= take_bit(rx_shift, miso, mode.lsb_first);
          end
          if (last_edge) begin
            state <= HOLD;
          end
        end

        HOLD: begin
          sclk <= mode.cpol;
          if (tick) begin
            state <= DONE;
            cs_n  <= 1'b1;
            done  <= 1'b1;
            dout  <= rx_shift;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          mosi  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_cfg.sv
module tb_spi_master_cfg;

  localparam int DW   = 12;
  localparam int CD   = 4;
  localparam int DW2  = 8;
  localparam int CD2  = 2;
  // posedges from the accepting edge to the edge that raises done
  localparam int LAT  = CD * (2 * DW + 2);
  localparam int LAT2 = CD2 * (2 * DW2 + 2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst_n, newd, cpol, cpha, lsb_first, miso;
  logic [DW-1:0] din, dout;
  logic          sclk, mosi, cs_n, done, busy;

  logic           newd2, cpol2, cpha2, lsb2;
  logic [DW2-1:0] din2, dout2;
  logic           sclk2, mosi2, cs_n2, done2, busy2;

  logic          lb;
  logic          slave_miso;
  assign miso = lb ? mosi : slave_miso;

  spi_master_cfg #(.DATA_W(DW), .CLK_DIV(CD)) dut (
    .clk(clk), .rst_n(rst_n), .newd(newd), .din(din), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb_first), .miso(miso), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
    .dout(dout), .done(done), .busy(busy)
  );

  spi_master_cfg #(.DATA_W(DW2), .CLK_DIV(CD2)) dut2 (
    .clk(clk), .rst_n(rst_n), .newd(newd2), .din(din2), .cpol(cpol2), .cpha(cpha2),
    .lsb_first(lsb2), .miso(mosi2), .sclk(sclk2), .mosi(mosi2), .cs_n(cs_n2),
    .dout(dout2), .done(done2), .busy(busy2)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural SPI slave: reacts to SCLK edges according to the mode under test.
  logic [DW-1:0] slv_tx, slv_rx;
  logic          slv_first;
  int            slv_idx;
  logic          m_cpol, m_cpha, m_lsb;

  function automatic int pos(input int i);
    return m_lsb ? i : DW - 1 - i;
  endfunction

  initial slave_miso = 1'b0;

  always @(negedge cs_n) begin
    slv_idx = 0;
    slv_rx  = '0;
    if (!m_cpha) slave_miso = slv_tx[pos(0)];
  end

  always @(sclk) begin
    if (cs_n === 1'b0 && slv_idx < DW) begin
      if ((sclk != m_cpol) ^ m_cpha) begin
        // sampling edge
        if (slv_idx == 0) slv_first = mosi;
        slv_rx[pos(slv_idx)] = mosi;
        if (m_cpha) slv_idx++;
      end else begin
        // launching edge
        if (!m_cpha) slv_idx++;
        if (slv_idx < DW) slave_miso = slv_tx[pos(slv_idx)];
      end
    end
  end

  int            r_lat, r_cslow, r_ndone;
  logic          r_sclk, r_csdone;
  logic [DW-1:0] r_dout;

  task automatic run_xfer(input logic [DW-1:0] d, input logic p, input logic h, input logic l,
                          input int intf_at, input int rst_at);
    int k;
    @(negedge clk);
    cpol = p; cpha = h; lsb_first = l; din = d;
    m_cpol = p; m_cpha = h; m_lsb = l;
    @(negedge clk);
    chk("sclk_idle_eq_cpol", sclk, p);
    newd = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    chk("busy_after_accept", busy, 1);
    r_cslow = (cs_n == 1'b0) ? 1 : 0;
    r_ndone = 0; r_lat = -1; r_sclk = 1'b0; r_csdone = 1'b0; r_dout = '0;
    for (int i = 1; i <= LAT + 30; i++) begin
      @(negedge clk);
      newd  = (i == intf_at);
      if (i == intf_at) din = '1;
      rst_n = (i != rst_at);
      @(posedge clk); #1;
      if (i == rst_at) begin
        chk("rst_cs_n", cs_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_sclk", sclk, 0);
        chk("rst_done", done, 0);
        chk("rst_dout", dout, 0);
        chk("rst_mosi", mosi, 0);
      end
      if (cs_n == 1'b0) r_cslow++;
      if (done === 1'b1) begin
        r_ndone++;
        if (r_ndone == 1) begin
          r_lat = cyc - k; r_sclk = sclk; r_csdone = cs_n; r_dout = dout;
        end
      end
    end
    @(negedge clk);
    newd = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic check_xfer(input string tag, input logic [DW-1:0] d, input logic p,
                            input logic [DW-1:0] exp_rx);
    chk({tag, "_ndone"}, r_ndone, 1);
    chk({tag, "_latency"}, r_lat, LAT);
    chk({tag, "_cs_low_cycles"}, r_cslow, LAT);
    chk({tag, "_cs_n_at_done"}, r_csdone, 1);
    chk({tag, "_sclk_at_done"}, r_sclk, p);
    chk({tag, "_dout"}, r_dout, exp_rx);
    chk({tag, "_slave_rx"}, slv_rx, d);
  endtask

  task automatic run2(input logic [DW2-1:0] d, input logic p, input logic h, input logic l);
    int k, lat, nd;
    logic [DW2-1:0] got;
    @(negedge clk);
    din2 = d; cpol2 = p; cpha2 = h; lsb2 = l;
    @(negedge clk);
    newd2 = 1'b1;
    @(posedge clk); #1;
    k = cyc; lat = -1; nd = 0; got = '0;
    for (int i = 1; i <= LAT2 + 20; i++) begin
      @(negedge clk);
      newd2 = 1'b0;
      @(posedge clk); #1;
      if (done2 === 1'b1) begin
        nd++;
        if (nd == 1) begin lat = cyc - k; got = dout2; end
      end
    end
    chk("w8_ndone", nd, 1);
    chk("w8_latency", lat, LAT2);
    chk("w8_dout", got, d);
  endtask

  logic [DW-1:0] rd;
  logic          rp, rh, rl;
  int            dtimes[3];
  int            nd5, hrun;
  logic          seen_low;

  initial begin
    rst_n = 1'b0; newd = 1'b0; din = '0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    newd2 = 1'b0; din2 = '0; cpol2 = 1'b0; cpha2 = 1'b0; lsb2 = 1'b0;
    lb = 1'b1; slv_tx = '0; slv_first = 1'b0; slv_idx = 0;
    m_cpol = 1'b0; m_cpha = 1'b0; m_lsb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sclk", sclk, 0);
    chk("reset_mosi", mosi, 0);
    chk("reset_cs_n", cs_n, 1);
    chk("reset_dout", dout, 0);
    chk("reset_done", done, 0);
    chk("reset_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // loopback, mode 0, MSB first
    lb = 1'b1;
    run_xfer(12'hA5C, 1'b0, 1'b0, 1'b0, 0, 0);
    check_xfer("t1", 12'hA5C, 1'b0, 12'hA5C);

    // slave returns its own word, mode 3
    lb = 1'b0; slv_tx = 12'h3C1;
    run_xfer(12'h0F0, 1'b1, 1'b1, 1'b0, 0, 0);
    check_xfer("t2", 12'h0F0, 1'b1, 12'h3C1);

    // modes 1 and 2, LSB first, loopback
    lb = 1'b1;
    run_xfer(12'h001, 1'b0, 1'b1, 1'b1, 0, 0);
    check_xfer("t3m1", 12'h001, 1'b0, 12'h001);
    chk("t3m1_first_mosi", slv_first, 1);
    run_xfer(12'h001, 1'b1, 1'b0, 1'b1, 0, 0);
    check_xfer("t3m2", 12'h001, 1'b1, 12'h001);
    chk("t3m2_first_mosi", slv_first, 1);

    // request while busy is ignored
    run_xfer(12'h5A3, 1'b0, 1'b0, 1'b0, 20, 0);
    check_xfer("t4", 12'h5A3, 1'b0, 12'h5A3);

    // back-to-back with newd held high
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; din = 12'hC3A;
    m_cpol = 1'b0; m_cpha = 1'b0; m_lsb = 1'b0;
    @(negedge clk);
    newd = 1'b1;
    nd5 = 0; hrun = 0; seen_low = 1'b0;
    for (int i = 0; i < 3 * (LAT + 2) + 60 && nd5 < 3; i++) begin
      @(posedge clk); #1;
      if (cs_n == 1'b1) begin
        hrun++;
      end else begin
        if (nd5 > 0 && hrun > 0) chk("t5_cs_high_gap_ge2", (hrun >= 2), 1);
        hrun = 0;
      end
      if (done === 1'b1) begin
        dtimes[nd5] = cyc;
        chk("t5_dout", dout, 12'hC3A);
        nd5++;
      end
    end
    @(negedge clk);
    newd = 1'b0;
    chk("t5_ndone", nd5, 3);
    chk("t5_spacing_1", dtimes[1] - dtimes[0], LAT + 2);
    chk("t5_spacing_2", dtimes[2] - dtimes[1], LAT + 2);
    repeat (LAT + 10) @(posedge clk);

    // reset mid-transfer, then a normal transfer
    run_xfer(12'h6B2, 1'b0, 1'b0, 1'b0, 0, 50);
    chk("t6_no_done", r_ndone, 0);
    run_xfer(12'h29E, 1'b0, 1'b0, 1'b0, 0, 0);
    check_xfer("t6_after", 12'h29E, 1'b0, 12'h29E);

    // randomized transfers against the slave / loopback reference
    for (int t = 0; t < 6; t++) begin
      rd = DW'($urandom);
      rp = 1'($urandom_range(0, 1));
      rh = 1'($urandom_range(0, 1));
      rl = 1'($urandom_range(0, 1));
      lb = 1'($urandom_range(0, 1));
      slv_tx = DW'($urandom);
      run_xfer(rd, rp, rh, rl, 0, 0);
      check_xfer("rand", rd, rp, lb ? rd : slv_tx);
    end

    // narrow, fast configuration
    run2(8'hA5, 1'b0, 1'b0, 1'b0);
    run2(8'h3C, 1'b1, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
